// File: rtl/mvb_merge_rr.sv
// Round-robin merge of INPUT_PORTS MVB streams into one registered MVB output.
// Whole words are granted one per cycle in rotating order starting at the priority pointer.
module mvb_merge_rr #(
  parameter int INPUT_PORTS = 2,
  parameter int ITEMS       = 4,
  parameter int ITEM_WIDTH  = 8,
  parameter int DROP_EMPTY  = 1,
  localparam int PORT_W     = (INPUT_PORTS > 1) ? $clog2(INPUT_PORTS) : 1,
  localparam int WORD_W     = ITEMS * ITEM_WIDTH
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic [INPUT_PORTS*WORD_W-1:0]       RX_DATA,
  input  logic [INPUT_PORTS*ITEMS-1:0]        RX_VLD,
  input  logic [INPUT_PORTS-1:0]              RX_SRC_RDY,
  output logic [INPUT_PORTS-1:0]              RX_DST_RDY,
  output logic [WORD_W-1:0]                   TX_DATA,
  output logic [ITEMS-1:0]                    TX_VLD,
  output logic [PORT_W-1:0]                   TX_PORT,
  output logic                                TX_SRC_RDY,
  input  logic                                TX_DST_RDY
);

  logic                   stage_free_s;
  logic                   grant_found_s;
  logic                   accept_s;
  logic                   word_empty_s;
  logic                   load_s;
  int                     best_rank_s;
  int                     rank_s;
  logic [PORT_W-1:0]      grant_idx_s;
  logic [PORT_W-1:0]      ptr_next_s;
  logic [WORD_W-1:0]      sel_data_s;
  logic [ITEMS-1:0]       sel_vld_s;
  logic [INPUT_PORTS-1:0] rx_dst_rdy_s;

  logic [PORT_W-1:0]      ptr_d,        ptr_q;
  logic                   tx_src_rdy_d, tx_src_rdy_q;
  logic [WORD_W-1:0]      tx_data_d,    tx_data_q;
  logic [ITEMS-1:0]       tx_vld_d,     tx_vld_q;
  logic [PORT_W-1:0]      tx_port_d,    tx_port_q;

  // Grant: the requesting port with the smallest distance from ptr (modulo INPUT_PORTS).
  always_comb begin
    best_rank_s = INPUT_PORTS;
    rank_s      = 0;
    grant_idx_s = '0;
    for (int p = 0; p < INPUT_PORTS; p++) begin
      rank_s      = (p >= int'(ptr_q)) ? (p - int'(ptr_q)) : (p + INPUT_PORTS - int'(ptr_q));
      grant_idx_s = (RX_SRC_RDY[p] && (rank_s < best_rank_s)) ? PORT_W'(p) : grant_idx_s;
      best_rank_s = (RX_SRC_RDY[p] && (rank_s < best_rank_s)) ? rank_s : best_rank_s;
    end
    grant_found_s = (best_rank_s < INPUT_PORTS);
  end

  // Word mux for the granted port; feeds only the output register.
  always_comb begin
    sel_data_s = '0;
    sel_vld_s  = '0;
    for (int p = 0; p < INPUT_PORTS; p++) begin
      sel_data_s = (grant_idx_s == PORT_W'(p)) ? RX_DATA[p*WORD_W +: WORD_W] : sel_data_s;
      sel_vld_s  = (grant_idx_s == PORT_W'(p)) ? RX_VLD[p*ITEMS +: ITEMS]    : sel_vld_s;
    end
  end

  // Handshake: RX_DST_RDY never depends on RX_DATA or RX_VLD.
  always_comb begin
    stage_free_s = !tx_src_rdy_q || TX_DST_RDY;
    accept_s     = grant_found_s && stage_free_s && !RESET;
    for (int p = 0; p < INPUT_PORTS; p++) begin
      rx_dst_rdy_s[p] = accept_s && (grant_idx_s == PORT_W'(p));
    end
    word_empty_s = (sel_vld_s == {ITEMS{1'b0}});
    load_s       = accept_s && !((DROP_EMPTY != 0) && word_empty_s);
    ptr_next_s   = (grant_idx_s == PORT_W'(INPUT_PORTS - 1)) ? {PORT_W{1'b0}}
                                                             : grant_idx_s + PORT_W'(1);
  end

  // Next-state: a dropped empty word still advances ptr but leaves the TX register alone.
  always_comb begin
    ptr_d        = accept_s ? ptr_next_s : ptr_q;
    tx_src_rdy_d = load_s || (tx_src_rdy_q && !TX_DST_RDY);
    tx_data_d    = load_s ? sel_data_s  : tx_data_q;
    tx_vld_d     = load_s ? sel_vld_s   : tx_vld_q;
    tx_port_d    = load_s ? grant_idx_s : tx_port_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q        <= '0;
      tx_src_rdy_q <= 1'b0;
      tx_data_q    <= '0;
      tx_vld_q     <= '0;
      tx_port_q    <= '0;
    end else begin
      ptr_q        <= ptr_d;
      tx_src_rdy_q <= tx_src_rdy_d;
      tx_data_q    <= tx_data_d;
      tx_vld_q     <= tx_vld_d;
      tx_port_q    <= tx_port_d;
    end
  end

  assign RX_DST_RDY = rx_dst_rdy_s;
  assign TX_SRC_RDY = tx_src_rdy_q;
  assign TX_DATA    = tx_data_q;
  assign TX_VLD     = tx_vld_q;
  assign TX_PORT    = tx_port_q;

endmodule

// File: doc/mvb_merge_rr.md
# mvb_merge_rr

Round-robin merge of INPUT_PORTS independent MVB streams into one MVB output stream; the counterpart of the MVB fork. Whole MVB words are granted, one per cycle, to the requesting inputs in fair rotating order and pass through a single output register stage. The block sits wherever several MVB producers share one downstream consumer, such as the header, metadata or DMA request paths.

## Interface
- INPUT_PORTS, 2, number of RX MVB streams (≥2)
- ITEMS, 4, items per MVB word
- ITEM_WIDTH, 8, bits per item
- DROP_EMPTY, 1, 1 = accept and discard RX words with all VLD bits 0; 0 = forward them

- CLK  in  1  clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- RX_DATA  in  INPUT_PORTS*ITEMS*ITEM_WIDTH  item data; port i occupies slice i
- RX_VLD  in  INPUT_PORTS*ITEMS  per-item valid; port i occupies slice i
- RX_SRC_RDY  in  INPUT_PORTS  word present on port i
- RX_DST_RDY  out  INPUT_PORTS  word on port i accepted this cycle
- TX_DATA  out  ITEMS*ITEM_WIDTH  merged data
- TX_VLD  out  ITEMS  merged item valids
- TX_PORT  out  log2(INPUT_PORTS)  index of the source port of the current TX word
- TX_SRC_RDY  out  1  TX word valid
- TX_DST_RDY  in  1  downstream ready

## Operation
- A transfer occurs on port i when RX_SRC_RDY(i)=1 and RX_DST_RDY(i)=1. On TX, a transfer occurs when TX_SRC_RDY=1 and TX_DST_RDY=1.
- stage_free = not TX_SRC_RDY or TX_DST_RDY.
- Priority pointer ptr is 0..INPUT_PORTS-1. Grant goes to the first port with RX_SRC_RDY=1 in order ptr, ptr+1, …, wrapping modulo INPUT_PORTS.
- RX_DST_RDY(g)=stage_free for the granted port g. All other RX_DST_RDY bits are 0. At most one RX_DST_RDY bit is set per cycle.
- On an RX transfer from port g:
  - ptr ← (g+1) mod INPUT_PORTS. The wrap from the last port goes to 0.
  - If DROP_EMPTY=1 and RX_VLD slice g is all zero, the word is consumed and no TX word is produced. TX_SRC_RDY ← 0 if the old word drained; otherwise the TX register is unchanged.
  - Otherwise TX_DATA, TX_VLD ← slice g, TX_PORT ← g, and TX_SRC_RDY ← 1.
- If there is no RX transfer and the TX word drains, TX_SRC_RDY ← 0. TX_DATA, TX_VLD and TX_PORT hold their values.
- ptr is unchanged when no RX transfer occurs. A pending request keeps its rank, so any port waits at most INPUT_PORTS-1 grants.
- Data and VLD are passed bit-exact. Items are never reordered, compacted or split.
- With DROP_EMPTY=0, all-zero-VLD words are forwarded like any other word.

## Timing
- Reset values, applied at the rising edge with RESET=1: TX_SRC_RDY=0, TX_VLD=0, TX_DATA=0, TX_PORT=0, ptr=0.
- During reset RX_DST_RDY is all 0. Reset asserted mid-operation discards the held TX word without a TX transfer.
- Latency is 1 cycle: a word accepted at edge n appears on TX after edge n, valid for the TX transfer at edge n+1.
- RX_DST_RDY is combinational from RX_SRC_RDY, TX_SRC_RDY, TX_DST_RDY and ptr. There is no combinational path from RX_DATA or RX_VLD to any output.
- Throughput is one word per cycle when TX_DST_RDY=1 continuously. There are no bubbles on port switches.
- Backpressure: when TX_SRC_RDY=1 and TX_DST_RDY=0, all RX_DST_RDY are 0 and TX_DATA, TX_VLD and TX_PORT are stable until the TX transfer.
- A simultaneous TX drain and RX accept in the same cycle is a full-rate pass-through with no loss.
- RX sources hold their data while RX_SRC_RDY=1 and no transfer has occurred. The block does not check this.

## Test plan
- Single port: INPUT_PORTS=2, port 0 sends words A0..A9, port 1 idle, TX_DST_RDY=1 → TX carries A0..A9 in order on consecutive cycles, first one cycle after the first accept, TX_PORT=0.
- Fairness: 3 ports all continuously ready with streams Ak, Bk, Ck → TX order A0,B0,C0,A1,B1,C1,…; each port gets exactly 1/3 of the words over 300 cycles.
- Wrap and skip: ptr=2 with only ports 0 and 2 requesting (INPUT_PORTS=3) → grant order 2,0,2,0; port 1 is never granted.
- Backpressure: TX_DST_RDY held 0 for 5 cycles with a word on TX → TX_DATA, TX_VLD and TX_PORT are stable and RX_DST_RDY=0. On release, words resume with no loss or duplication.
- Empty words: RX_VLD=0000 with DROP_EMPTY=1 → RX_DST_RDY=1, no TX word, ptr advances. Same stimulus with DROP_EMPTY=0 → TX word with TX_VLD=0000.
- Reset mid-stream: RESET for 1 cycle while TX_SRC_RDY=1 → TX_SRC_RDY=0 next cycle and ptr=0. The next grant goes to the lowest ready port.
- Random regression: 2000 transactions per port with random SRC_RDY, DST_RDY and VLD patterns. The scoreboard checks per-port ordering and that every accepted word appears exactly once.
